// File: rtl/sae_stream_ctrl_if.sv
// Plaintext-in and ciphertext-out character streams of the SAE message sequencer.
// The master modport is the sequencer side; the slave modport is the source/sink side.
interface sae_stream_ctrl_if;
  logic       in_valid;
  logic [7:0] in_char;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_char;
  logic       out_ready;

  modport master (
    input  in_valid, in_char, out_ready,
    output in_ready, out_valid, out_char
  );

  modport slave (
    output in_valid, in_char, out_ready,
    input  in_ready, out_valid, out_char
  );
endinterface

// File: rtl/sae_stream_ctrl.sv
// Message-level sequencer for the character-wise SAE encryption core: feeds plaintext
// one character at a time, waits for C_ready and streams the ciphertext out.
module sae_stream_ctrl #(
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [1:0]  MODE_ENC  = 2'b10,
  parameter logic [1:0]  MODE_IDLE = 2'b00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       key,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             abort,
  sae_stream_ctrl_if.master strm,
  output logic [1:0]       core_mode,
  output logic [7:0]       core_plaintext,
  output logic [7:0]       core_key,
  input  logic [7:0]       core_ctext,
  input  logic             core_c_ready,
  input  logic             core_err,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT - 32'd1);
  localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_nxt_s;
  logic [LEN_W-1:0] cnt_r, msg_len_r, cnt_inc_s;
  logic [7:0]       tcnt_r;
  logic             in_ready_r, out_valid_r;
  logic [7:0]       out_char_r;
  logic             start_acc_s, load_fire_s, capture_s, out_fire_s, err_set_s;
  logic [1:0]       err_code_nxt_s;

  assign strm.in_ready  = in_ready_r;
  assign strm.out_valid = out_valid_r;
  assign strm.out_char  = out_char_r;
  assign cnt_inc_s      = cnt_r + CNT_ONE;

  // Next-state and per-cycle control strobes; abort in a busy state overrides everything.
  always_comb begin
    state_nxt_s    = state_r;
    start_acc_s    = 1'b0;
    load_fire_s    = 1'b0;
    capture_s      = 1'b0;
    out_fire_s     = 1'b0;
    err_set_s      = 1'b0;
    err_code_nxt_s = 2'b00;
    if (abort && (state_r != S_IDLE)) begin
      state_nxt_s    = S_IDLE;
      err_set_s      = 1'b1;
      err_code_nxt_s = 2'b11;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start && !abort) begin
            start_acc_s = 1'b1;
            state_nxt_s = (msg_len == CNT_ZERO) ? S_DONE : S_LOAD;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_LOAD: begin
          if (strm.in_valid && in_ready_r) begin
            load_fire_s = 1'b1;
            state_nxt_s = S_ISSUE;
          end else begin
            state_nxt_s = S_LOAD;
          end
        end
        S_ISSUE: begin
          if (core_c_ready && core_err) begin
            err_set_s      = 1'b1;
            err_code_nxt_s = 2'b01;
            state_nxt_s    = S_IDLE;
          end else if (core_c_ready) begin
            capture_s   = 1'b1;
            state_nxt_s = S_OUT;
          end else if (tcnt_r == TMO_LAST) begin
            err_set_s      = 1'b1;
            err_code_nxt_s = 2'b10;
            state_nxt_s    = S_IDLE;
          end else begin
            state_nxt_s = S_ISSUE;
          end
        end
        S_OUT: begin
          if (strm.out_ready && out_valid_r) begin
            out_fire_s  = 1'b1;
            state_nxt_s = (cnt_inc_s == msg_len_r) ? S_DONE : S_LOAD;
          end else begin
            state_nxt_s = S_OUT;
          end
        end
        S_DONE:  state_nxt_s = S_IDLE;
        default: state_nxt_s = S_IDLE;
      endcase
    end
  end

  // State, datapath and registered outputs; outputs follow the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= S_IDLE;
      cnt_r          <= CNT_ZERO;
      msg_len_r      <= CNT_ZERO;
      tcnt_r         <= 8'd0;
      in_ready_r     <= 1'b0;
      out_valid_r    <= 1'b0;
      out_char_r     <= 8'd0;
      core_mode      <= MODE_IDLE;
      core_plaintext <= 8'd0;
      core_key       <= 8'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      err_code       <= 2'b00;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == S_LOAD);
      out_valid_r <= (state_nxt_s == S_OUT);
      busy        <= (state_nxt_s != S_IDLE);
      done        <= (state_nxt_s == S_DONE);
      core_mode   <= (state_nxt_s == S_ISSUE) ? MODE_ENC : MODE_IDLE;
      if (start_acc_s) begin
        core_key  <= key;
        msg_len_r <= msg_len;
        cnt_r     <= CNT_ZERO;
        err       <= 1'b0;
        err_code  <= 2'b00;
      end
      if (load_fire_s) begin
        core_plaintext <= strm.in_char;
        tcnt_r         <= 8'd0;
      end else if (state_r == S_ISSUE) begin
        tcnt_r <= tcnt_r + 8'd1;
      end
      if (capture_s) begin
        out_char_r <= core_ctext;
      end
      if (out_fire_s) begin
        cnt_r <= cnt_inc_s;
      end
      if (err_set_s) begin
        err      <= 1'b1;
        err_code <= err_code_nxt_s;
      end
    end
  end

endmodule

// File: tb/tb_sae_stream_ctrl.sv
// Self-checking bench for sae_stream_ctrl: table-driven messages against a core stub,
// a ciphertext scoreboard, and hand sequences for timing, timeout, abort and reset.
module tb_sae_stream_ctrl;
  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [7:0] key;
  logic [7:0] msg_len;
  logic [1:0] core_mode;
  logic [7:0] core_plaintext, core_key, core_ctext;
  logic       core_c_ready, core_err;
  logic       busy, done, err;
  logic [1:0] err_code;

  sae_stream_ctrl_if bus ();

  sae_stream_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .msg_len(msg_len), .abort(abort),
    .strm(bus), .core_mode(core_mode), .core_plaintext(core_plaintext), .core_key(core_key),
    .core_ctext(core_ctext), .core_c_ready(core_c_ready), .core_err(core_err),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Core stub: C_ready on the third consecutive encrypt cycle, ciphertext = ptxt + key.
  logic [7:0] stub_cnt;
  logic       stub_hang;
  always_ff @(posedge clk) stub_cnt <= (core_mode == 2'b10) ? stub_cnt + 8'd1 : 8'd0;
  assign core_c_ready = !stub_hang && (core_mode == 2'b10) && (stub_cnt == 8'd2);
  assign core_ctext   = core_plaintext + core_key;
  assign core_err     = (core_plaintext == 8'h00);

  typedef struct packed {
    logic [7:0]      key;
    logic [7:0]      len;
    logic [3:0][7:0] chars;
    logic [7:0]      stall;
    logic [7:0]      n_out;
    logic [3:0][7:0] outs;
    logic            exp_done;
    logic [1:0]      exp_code;
  } vec_t;

  vec_t       vecs [4];
  logic [7:0] sb_q [$];
  int         checks = 0, errors = 0;
  int         done_cnt = 0, enc_cycles = 0, wait_cnt = 0, stall_len = 0;
  bit         stalled = 1'b0;
  logic [7:0] held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1'b0);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_out_char"}, bus.out_char, 8'h00);
    check({tag, "_core_mode"}, core_mode, 2'b00);
    check({tag, "_core_ptxt"}, core_plaintext, 8'h00);
    check({tag, "_core_key"}, core_key, 8'h00);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_err_code"}, err_code, 2'b00);
  endtask

  task automatic send_char(input logic [7:0] ch, output bit ok);
    int cyc = 0;
    bus.in_valid = 1'b1;
    bus.in_char  = ch;
    while (!bus.in_ready && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    ok = bus.in_ready;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int cyc = 0;
    while (busy && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    ok = !busy;
  endtask

  task automatic do_start(input logic [7:0] k, input logic [7:0] len);
    start = 1'b1; key = k; msg_len = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    stall_len = int'(v.stall);
    done_cnt  = 0;
    do_start(v.key, v.len);
    check("start_busy", busy, 1'b1);
    check("start_in_ready", bus.in_ready, 1'b1);
    check("start_err_clear", err, 1'b0);
    for (int i = 0; i < int'(v.len); i++) begin
      if (i < int'(v.n_out)) sb_q.push_back(v.outs[i]);
      send_char(v.chars[i], ok);
      check("in_handshake", ok, 1'b1);
    end
    wait_idle(ok);
    check("msg_idle", ok, 1'b1);
    check("msg_done_cnt", done_cnt, {31'd0, v.exp_done});
    check("msg_err", err, (v.exp_code != 2'b00));
    check("msg_err_code", err_code, v.exp_code);
    check("msg_core_mode", core_mode, 2'b00);
    check("msg_sb_empty", sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Output monitor / scoreboard, sampled on the falling edge.
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled  = 1'b0;
        wait_cnt = 0;
      end else begin
        if (done === 1'b1) done_cnt++;
        if (core_mode === 2'b10) enc_cycles++;
        if (bus.out_valid === 1'b1) begin
          if (stalled) check("out_hold", bus.out_char, held);
          if (bus.out_ready) begin
            if (sb_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL out_unexpected: got %0h, expected no output", bus.out_char);
            end else begin
              exp = sb_q.pop_front();
              check("out_char", bus.out_char, exp);
            end
            stalled  = 1'b0;
            wait_cnt = 0;
          end else begin
            stalled = 1'b1;
            held    = bus.out_char;
            wait_cnt++;
          end
        end else begin
          stalled  = 1'b0;
          wait_cnt = 0;
        end
      end
    end
  end

  // Output sink: holds out_ready low for stall_len cycles of each presented character.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = (wait_cnt >= stall_len);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int c;
    int enc0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; key = 8'h00; msg_len = 8'h00;
    bus.in_valid = 1'b0; bus.in_char = 8'h00; stub_hang = 1'b0;

    vecs[0] = '{8'hC8, 8'd1, {8'h00, 8'h00, 8'h00, 8'h7F}, 8'd0, 8'd1,
                {8'h00, 8'h00, 8'h00, 8'h47}, 1'b1, 2'b00};
    vecs[1] = '{8'h01, 8'd3, {8'h00, 8'h43, 8'h42, 8'h41}, 8'd3, 8'd3,
                {8'h00, 8'h44, 8'h43, 8'h42}, 1'b1, 2'b00};
    vecs[2] = '{8'h01, 8'd2, {8'h00, 8'h00, 8'h00, 8'h41}, 8'd0, 8'd1,
                {8'h00, 8'h00, 8'h00, 8'h42}, 1'b0, 2'b01};
    vecs[3] = '{8'h10, 8'd4, {8'hFF, 8'h80, 8'h05, 8'hF0}, 8'd1, 8'd4,
                {8'h0F, 8'h90, 8'h15, 8'h00}, 1'b1, 2'b00};

    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Per-character latency and next in_ready timing.
    stall_len = 0; done_cnt = 0;
    do_start(8'h10, 8'd2);
    sb_q.push_back(8'h30);
    send_char(8'h20, ok);
    check("lat_mode_enc", core_mode, 2'b10);
    c = 0;
    while (!bus.out_valid && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    check("lat_out_valid_cycle", c, 3);
    @(posedge clk); #1;
    check("lat_next_in_ready", bus.in_ready, 1'b1);
    sb_q.push_back(8'h31);
    send_char(8'h21, ok);
    wait_idle(ok);
    check("lat_idle", ok, 1'b1);
    check("lat_done_cnt", done_cnt, 1);
    check("lat_sb_empty", sb_q.size(), 0);

    // Hung core: timeout after exactly 16 cycles in ISSUE.
    stub_hang = 1'b1;
    do_start(8'h00, 8'd1);
    send_char(8'h33, ok);
    repeat (15) begin
      @(posedge clk); #1;
    end
    check("tmo_not_yet", err, 1'b0);
    check("tmo_mode_still_enc", core_mode, 2'b10);
    @(posedge clk); #1;
    check("tmo_err", err, 1'b1);
    check("tmo_code", err_code, 2'b10);
    check("tmo_mode_idle", core_mode, 2'b00);
    check("tmo_busy", busy, 1'b0);
    stub_hang = 1'b0;

    // Zero-length message: done next cycle, no core activity, error cleared.
    @(posedge clk); #1;
    enc0 = enc_cycles; done_cnt = 0;
    do_start(8'h55, 8'd0);
    check("zero_done", done, 1'b1);
    check("zero_busy", busy, 1'b1);
    check("zero_err_clear", err, 1'b0);
    @(posedge clk); #1;
    check("zero_done_fall", done, 1'b0);
    check("zero_busy_fall", busy, 1'b0);
    check("zero_no_core", enc_cycles, enc0);
    check("zero_done_cnt", done_cnt, 1);

    // Abort while the core is working.
    do_start(8'h00, 8'd1);
    send_char(8'h05, ok);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_code", err_code, 2'b11);
    check("abort_err", err, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_mode", core_mode, 2'b00);
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_output", bus.out_valid, 1'b0);

    // Reset while an output is stalled.
    stall_len = 100; done_cnt = 0;
    do_start(8'h01, 8'd2);
    send_char(8'h10, ok);
    c = 0;
    while (!bus.out_valid && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    check("rst_reached_out", bus.out_valid, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset("mid");
    rst = 1'b0;
    stall_len = 0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_no_done", done_cnt, 0);
    check("rst_stays_idle", busy, 1'b0);
    check("final_sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sae_stream_ctrl.md
# sae_stream_ctrl

Message-level sequencer for the character-wise SAE encryption core (`encryption`). It accepts a key and a message length, pulls plaintext characters over a valid/ready input stream and drives them one at a time into the core. It waits for the core's `C_ready`, then presents each ciphertext character on a valid/ready output stream. It sits between the upstream character source and the core, owning the core's `mode`, `Plaintext` and `Public_key` inputs, and aborts cleanly on core errors or a hung core.

## Interface
- `LEN_W`, default 8: width of the message-length and character counters.
- `TIMEOUT`, default 16: maximum cycles to wait for `C_ready` per character (1..255).
- `MODE_ENC`, default 2'b10: core mode value that requests encryption.
- `MODE_IDLE`, default 2'b00: core mode value while the core is not in use.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `start` in 1: start a message; sampled only in IDLE.
- `key` in 8: public key; latched on an accepted `start`.
- `msg_len` in LEN_W: number of characters; latched on an accepted `start`.
- `abort` in 1: cancel the current message at any state.
- `in_valid` / `in_char` / `in_ready`: in / in 8 / out. Plaintext input stream.
- `out_valid` / `out_char` / `out_ready`: out / out 8 / in. Ciphertext output stream.
- `core_mode` out 2, `core_plaintext` out 8, `core_key` out 8: drive the core's `mode`, `Plaintext` and `Public_key`.
- `core_ctext` in 8, `core_c_ready` in 1, `core_err` in 1: from the core's `Char_ciphertext`, `C_ready` and `err_invalid_ptxt`.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse when a message completes without error.
- `err` out 1, `err_code` out 2: sticky error. Codes are 01 = invalid plaintext, 10 = core timeout, 11 = abort. Cleared by the next accepted `start`.

## Operation
- States: IDLE, LOAD, ISSUE, OUT, DONE.
- IDLE:
  - `start` with `msg_len` != 0: latch `key` and `msg_len`, clear `cnt`, clear `err`/`err_code`, go to LOAD.
  - `start` with `msg_len` == 0: clear the error, go to DONE. No core activity.
- LOAD:
  - `in_ready` = 1.
  - On `in_valid & in_ready`: register `in_char` into `core_plaintext`, clear the timeout counter `tcnt`, go to ISSUE.
- ISSUE:
  - `core_mode` = MODE_ENC; `core_plaintext` and `core_key` are held stable; `tcnt` increments each cycle.
  - `core_c_ready & core_err`: `err` = 1, `err_code` = 01, go to IDLE. No output is produced.
  - `core_c_ready & !core_err`: capture `core_ctext` into `out_char`, go to OUT.
  - Otherwise, when `tcnt` == TIMEOUT-1 with no `core_c_ready`: `err_code` = 10, go to IDLE.
- OUT:
  - `out_valid` = 1; `out_char` is held stable until it is accepted.
  - On `out_ready`: `cnt` = `cnt` + 1. If the new `cnt` == `msg_len`, go to DONE; else go to LOAD.
- DONE: `done` = 1 for one cycle, then go to IDLE.
- `abort` overrides every other condition in every non-IDLE state: go to IDLE, `err_code` = 11, `core_mode` = MODE_IDLE. Any pending output is dropped.
- `abort` in IDLE has no effect. `abort` and `start` in the same IDLE cycle: `start` is ignored.
- `core_mode` = MODE_IDLE in every state except ISSUE.
- `core_key` equals the latched key from `start` until the next accepted `start`.
- `cnt` and `msg_len` are unsigned LEN_W bits. The maximum message is 2^LEN_W-1 characters, and `cnt` never wraps.
- `core_c_ready` and `core_err` are ignored outside ISSUE.

## Timing
- All outputs are registered.
- Reset values: `in_ready` = 0, `out_valid` = 0, `out_char` = 0, `core_mode` = MODE_IDLE, `core_plaintext` = 0, `core_key` = 0, `busy` = 0, `done` = 0, `err` = 0, `err_code` = 00. State returns to IDLE.
- Reset mid-message behaves identically to power-on reset. No `done` is issued, and the core is returned to MODE_IDLE on the next cycle.
- Start: accepted in cycle t. `busy` = 1 and `in_ready` = 1 at t+1.
- Per-character latency, with the input transferred at cycle t:
  - `core_mode` = MODE_ENC from t+1.
  - If the core raises `C_ready` in cycle t+1+L, then `out_valid` = 1 at t+2+L.
  - With `out_ready` held high, the next `in_ready` is at t+3+L.
- Completion: `done` is asserted the cycle after the last output handshake, and `busy` falls the cycle after `done`.
- A timeout is declared after exactly TIMEOUT cycles in ISSUE.

## Test plan
Bench core stub: asserts `C_ready` 2 cycles after seeing `mode` == 2'b10, returns `Char_ciphertext` = (`Plaintext` + `Public_key`) mod 256, and raises `err_invalid_ptxt` when `Plaintext` == 8'h00.
- Single character: `start`, key 8'hC8, `msg_len` 1, input 8'h7F, `out_ready` held 1. Expect one output 8'h47, then a `done` pulse, `err` = 0, and `core_mode` back to 00.
- Three characters with backpressure: key 8'h01, inputs 8'h41, 8'h42, 8'h43, `out_ready` low for 3 cycles on each output. Expect outputs 8'h42, 8'h43, 8'h44 in order, each held stable while stalled, and `done` exactly once.
- Invalid plaintext: `msg_len` 2, inputs 8'h41 then 8'h00. Expect one output, then `err_code` = 01, no `done`, return to IDLE; the next `start` clears `err`.
- Timeout: the stub never asserts `C_ready`, TIMEOUT = 16. Expect `err_code` = 10 exactly 16 cycles after ISSUE entry, and `core_mode` = 00.
- Abort, zero length and reset: abort in ISSUE gives `err_code` = 11 and `busy` = 0 next cycle; `start` with `msg_len` 0 gives `done` 1 cycle later with no core activity; `rst` during OUT gives all reset values and no `done`.
